traffic_phase_sequencer: RTL and testbench



---
 rtl/traffic_pkg.sv | 29 ++
 rtl/traffic_phase_sequencer_phase_timer.sv | 27 ++
 rtl/traffic_phase_sequencer.sv | 107 ++++++++++
 tb/tb_traffic_phase_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase sequencer.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5,
    PED_WALK    = 3'd6
  } phase_e;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam int GREEN_MAIN_DEF = 10;
  localparam int YELLOW_DEF     = 3;
  localparam int ALL_RED_DEF    = 1;
  localparam int GREEN_SIDE_DEF = 6;
  localparam int WALK_DEF       = 5;
  localparam int CNT_W_DEF      = 8;

  function automatic bit dur_ok(input int d, input int w);
    return (d >= 1) && (d <= (1 << w) - 1);
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_phase_timer.sv
// Loadable seconds down-counter; last flags the tick that ends the phase.
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] remain,
  output logic             last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain <= RST_VAL;
    end else if (load) begin
      remain <= load_val;
    end else if (en && (remain != '0)) begin
      remain <= remain - CNT_W'(1);
    end
  end

  assign last = en && (remain == CNT_W'(1));

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Traffic light phase FSM with per-phase countdown and latched pedestrian walk.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int GREEN_MAIN_S = GREEN_MAIN_DEF,
  parameter int YELLOW_S     = YELLOW_DEF,
  parameter int ALL_RED_S    = ALL_RED_DEF,
  parameter int GREEN_SIDE_S = GREEN_SIDE_DEF,
  parameter int WALK_S       = WALK_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             ped_req,
  output logic [2:0]       main_light,
  output logic [2:0]       side_light,
  output logic             walk,
  output logic [CNT_W-1:0] remain,
  output logic [2:0]       phase,
  output logic             phase_done
);

  if (!dur_ok(GREEN_MAIN_S, CNT_W) || !dur_ok(YELLOW_S, CNT_W) || !dur_ok(ALL_RED_S, CNT_W) ||
      !dur_ok(GREEN_SIDE_S, CNT_W) || !dur_ok(WALK_S, CNT_W)) begin : g_bad_duration
    $error("traffic_phase_sequencer: every duration must be in 1..2**CNT_W-1");
  end

  phase_e           state, state_nxt;
  logic             advance, last, ped_pending;
  logic [CNT_W-1:0] load_val;

  function automatic logic [CNT_W-1:0] dur(input phase_e p);
    case (p)
      MAIN_YELLOW, SIDE_YELLOW: return CNT_W'(YELLOW_S);
      ALL_RED_A, ALL_RED_B:     return CNT_W'(ALL_RED_S);
      SIDE_GREEN:               return CNT_W'(GREEN_SIDE_S);
      PED_WALK:                 return CNT_W'(WALK_S);
      default:                  return CNT_W'(GREEN_MAIN_S);
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= MAIN_GREEN;
      phase_done  <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase_done <= advance;
      // A request arriving on the walk-entry clock is absorbed by that walk.
      if (advance && (state_nxt == PED_WALK)) begin
        ped_pending <= 1'b0;
      end else if (ped_req && (state != PED_WALK)) begin
        ped_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MAIN_GREEN:  if (last) state_nxt = MAIN_YELLOW;
      MAIN_YELLOW: if (last) state_nxt = ALL_RED_A;
      ALL_RED_A:   if (last) state_nxt = SIDE_GREEN;
      SIDE_GREEN:  if (last) state_nxt = SIDE_YELLOW;
      SIDE_YELLOW: if (last) state_nxt = ALL_RED_B;
      ALL_RED_B:   if (last) state_nxt = ped_pending ? PED_WALK : MAIN_GREEN;
      PED_WALK:    if (last) state_nxt = MAIN_GREEN;
      default:     state_nxt = MAIN_GREEN;
    endcase
  end

  // Every legal transition changes phase, so a change is exactly a phase entry.
  assign advance  = (state_nxt != state);
  assign load_val = dur(state_nxt);

  phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(CNT_W'(GREEN_MAIN_S))
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (advance),
    .load_val(load_val),
    .en      (tick),
    .remain  (remain),
    .last    (last)
  );

  always_comb begin
    main_light = RED;
    side_light = RED;
    walk       = 1'b0;
    case (state)
      MAIN_GREEN:  main_light = GREEN;
      MAIN_YELLOW: main_light = YELLOW;
      SIDE_GREEN:  side_light = GREEN;
      SIDE_YELLOW: side_light = YELLOW;
      PED_WALK:    walk = 1'b1;
      default:     ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Self-checking bench: vector table, directed corner sequences, random run vs. a phase-table model.
module tb_traffic_phase_sequencer;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light, side_light, phase;
  logic       walk, phase_done;
  logic [7:0] remain;

  traffic_phase_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .ped_req(ped_req),
    .main_light(main_light), .side_light(side_light), .walk(walk),
    .remain(remain), .phase(phase), .phase_done(phase_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase index, ticks left, pending request, entry pulse.
  int dur_tab[7] = '{10, 3, 1, 6, 3, 1, 5};
  int m_phase, m_remain;
  bit m_pend, m_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int succ(input int p, input bit pend);
    if (p == 5) return pend ? 6 : 0;
    if (p == 6) return 0;
    return p + 1;
  endfunction

  function automatic int exp_main(input int p);
    return (p == 0) ? 1 : (p == 1) ? 2 : 4;
  endfunction

  function automatic int exp_side(input int p);
    return (p == 3) ? 1 : (p == 4) ? 2 : 4;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_remain = dur_tab[0]; m_pend = 0; m_done = 0;
  endtask

  task automatic model_step(input bit t, input bit p);
    bit entering;
    int nxt;
    entering = 0;
    nxt = m_phase;
    if (t) begin
      if (m_remain == 1) begin
        nxt = succ(m_phase, m_pend);
        entering = 1;
      end else begin
        m_remain--;
      end
    end
    if (entering && nxt == 6) m_pend = 0;
    else if (p && m_phase != 6) m_pend = 1;
    if (entering) begin
      m_phase = nxt;
      m_remain = dur_tab[nxt];
    end
    m_done = entering;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".phase"}, int'(phase), m_phase);
    chk({tag, ".remain"}, int'(remain), m_remain);
    chk({tag, ".main_light"}, int'(main_light), exp_main(m_phase));
    chk({tag, ".side_light"}, int'(side_light), exp_side(m_phase));
    chk({tag, ".walk"}, int'(walk), (m_phase == 6) ? 1 : 0);
    chk({tag, ".phase_done"}, int'(phase_done), int'(m_done));
  endtask

  // Drive at negedge, clock once, compare at the following negedge.
  task automatic step(input bit t, input bit p, input string tag);
    tick = t;
    ped_req = p;
    @(posedge clk);
    model_step(t, p);
    @(negedge clk);
    cmp_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    tick = 0;
    ped_req = 0;
    rst_n = 0;
    #1;
    model_reset();
    cmp_model("reset_assert");
    @(negedge clk);
    rst_n = 1;
    step(0, 0, "reset_release");
  endtask

  typedef struct {
    bit t;
    bit p;
    int ph;
    int rem;
    bit done;
  } vec_t;

  vec_t tab[$];

  initial begin
    int nt, ndone, wclk, walks, first_done, back_at;
    bit seen, pr;
    int exp_t[6] = '{10, 13, 14, 20, 23, 24};
    int exp_p[6] = '{1, 2, 3, 4, 5, 0};

    // Vector table from reset: count down MAIN_GREEN, into yellow, all-red, side green.
    tab.push_back('{1, 0, 0, 9, 0});
    tab.push_back('{0, 0, 0, 9, 0});
    tab.push_back('{1, 0, 0, 8, 0});
    for (int r = 7; r >= 1; r--) tab.push_back('{1, 0, 0, r, 0});
    tab.push_back('{1, 0, 1, 3, 1});
    tab.push_back('{0, 0, 1, 3, 0});
    tab.push_back('{1, 1, 1, 2, 0});
    tab.push_back('{1, 0, 1, 1, 0});
    tab.push_back('{1, 0, 2, 1, 1});
    tab.push_back('{1, 0, 3, 6, 1});

    do_reset();
    for (int i = 0; i < tab.size(); i++) begin
      step(tab[i].t, tab[i].p, "table");
      chk("tab.phase", int'(phase), tab[i].ph);
      chk("tab.remain", int'(remain), tab[i].rem);
      chk("tab.done", int'(phase_done), int'(tab[i].done));
    end

    // Full cycle with a tick every 4 clocks, no pedestrian.
    do_reset();
    nt = 0; ndone = 0;
    for (int i = 0; i < 96; i++) begin
      step((i % 4) == 3, 0, "slow_cycle");
      if ((i % 4) == 3) begin
        nt++;
        if (nt < 10) chk("slow.main_remain", int'(remain), 10 - nt);
      end
      if (phase_done) begin
        if (ndone < 6) begin
          chk("slow.entry_tick", nt, exp_t[ndone]);
          chk("slow.entry_phase", int'(phase), exp_p[ndone]);
        end
        ndone++;
      end
    end
    chk("slow.entries", ndone, 6);

    // Single ped pulse in MAIN_GREEN, tick held high.
    do_reset();
    step(0, 1, "ped_pulse");
    seen = 0; wclk = 0;
    for (int i = 0; i < 60; i++) begin
      step(1, 0, "ped_pulse");
      if (phase == 3'd6) begin
        if (!seen) begin
          chk("ped.walk_on_entry", int'(walk), 1);
          chk("ped.remain_on_entry", int'(remain), 5);
        end
        seen = 1;
        wclk++;
      end else if (seen) begin
        break;
      end
    end
    chk("ped.walk_seen", int'(seen), 1);
    chk("ped.walk_clocks", wclk, 5);
    chk("ped.back_to_main", int'(phase), 0);
    walks = 0;
    for (int i = 0; i < 24; i++) begin
      step(1, 0, "ped_after");
      if (walk) walks++;
    end
    chk("ped.no_repeat", walks, 0);

    // Ped held high through the walk, dropped on MAIN_GREEN entry.
    do_reset();
    pr = 1; seen = 0; wclk = 0;
    for (int i = 0; i < 80; i++) begin
      step(1, pr, "ped_held");
      if (phase == 3'd6) begin
        seen = 1;
        wclk++;
      end else if (seen) begin
        break;
      end
    end
    chk("held.walk_seen", int'(seen), 1);
    chk("held.walk_clocks", wclk, 5);
    walks = 0;
    for (int i = 0; i < 30; i++) begin
      step(1, 0, "held_after");
      if (walk) walks++;
    end
    chk("held.no_repeat", walks, 0);

    // Tick held high: 10 clocks of MAIN_GREEN, 24-clock cycle.
    do_reset();
    first_done = 0; back_at = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1, 0, "tick_high");
      if (phase_done && first_done == 0) first_done = i;
      if (phase_done && phase == 3'd0 && back_at == 0) back_at = i;
    end
    chk("hold.main_green_clocks", first_done, 10);
    chk("hold.cycle_clocks", back_at, 24);

    // Illegal phase code recovers to MAIN_GREEN.
    do_reset();
    step(1, 0, "pre_illegal");
    force dut.state = phase_e'(3'd7);
    #1;
    release dut.state;
    #1;
    chk("illegal.forced", int'(phase), 7);
    @(posedge clk);
    @(negedge clk);
    chk("illegal.phase", int'(phase), 0);
    chk("illegal.remain", int'(remain), 10);
    chk("illegal.main_light", int'(main_light), 1);
    chk("illegal.side_light", int'(side_light), 4);
    chk("illegal.walk", int'(walk), 0);

    // Reset mid-SIDE_GREEN drops a pending request.
    do_reset();
    step(0, 1, "rst_mid");
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step(1, 0, "rst_mid");
      if (phase == 3'd3) begin
        seen = 1;
        break;
      end
    end
    chk("rst_mid.reached_side", int'(seen), 1);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, "rst_mid.quiet");
    walks = 0;
    for (int i = 0; i < 26; i++) begin
      step(1, 0, "rst_mid.after");
      if (walk) walks++;
    end
    chk("rst_mid.pending_lost", walks, 0);

    // Random run against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit t, p;
      if ((i / 200) % 3 == 2) t = 1;
      else t = ($urandom_range(0, 2) == 0);
      p = ($urandom_range(0, 40) == 0) || (((i / 500) % 2 == 1) && ($urandom_range(0, 3) == 0));
      step(t, p, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
